// File: rtl/divider_seq.sv
// divider_seq: iterative radix-2 restoring divider, one trial subtraction per cycle.
// Signed support (abs/negate, overflow detection) is compiled in when DIV_SIGNED_EN is defined.
module divider_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz,
    output logic             ov
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dmag, mag_a, mag_b, q_fix, r_fix, diff;
    logic [WIDTH:0] shifted;
    logic accept, exc, is_ov, ge, exc_dz, exc_ov;
    assign accept  = state == IDLE && start;
    assign exc     = divisor == '0 || is_ov;
    assign shifted = {rem, quo[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dmag};
    // true trial result is below dmag whenever it is kept, so WIDTH bits suffice
    assign diff    = shifted[WIDTH-1:0] - dmag;
`ifdef DIV_SIGNED_EN
    logic sa, sb, neg_q, neg_r;
    assign sa    = s & dividend[WIDTH-1];
    assign sb    = s & divisor[WIDTH-1];
    assign mag_a = sa ? -dividend : dividend;
    assign mag_b = sb ? -divisor : divisor;
    assign is_ov = s && dividend == {1'b1, {(WIDTH-1){1'b0}}} && &divisor;
    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= sa ^ sb;
            neg_r <= sa;
        end
    end
`else
    logic unused_s;
    assign unused_s = s;
    assign mag_a    = dividend;
    assign mag_b    = divisor;
    assign is_ov    = 1'b0;
    assign q_fix    = quo;
    assign r_fix    = rem;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end
    always_comb begin
        nxt = state;
        if (accept)                                     nxt = exc ? FIX : RUN;
        else if (state == RUN && cnt == CNT_W'(WIDTH-1)) nxt = FIX;
        else if (state == FIX)                          nxt = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
            ov        <= 1'b0;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dmag      <= '0;
            exc_dz    <= 1'b0;
            exc_ov    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy   <= 1'b1;
                dz     <= 1'b0;
                ov     <= 1'b0;
                cnt    <= '0;
                rem    <= '0;
                // exception path keeps the raw dividend for the divide-by-zero remainder
                quo    <= exc ? dividend : mag_a;
                dmag   <= mag_b;
                exc_dz <= divisor == '0;
                exc_ov <= is_ov;
            end else if (state == RUN) begin
                rem <= ge ? diff : shifted[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], ge};
                cnt <= cnt + 1'b1;
            end else if (state == FIX) begin
                busy      <= 1'b0;
                done      <= 1'b1;
                quotient  <= exc_dz ? '1 : exc_ov ? {1'b1, {(WIDTH-1){1'b0}}} : q_fix;
                remainder <= exc_dz ? quo : exc_ov ? '0 : r_fix;
                dz        <= exc_dz;
                ov        <= exc_ov;
            end
        end
    end
endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: directed vectors for divider_seq; signed expectations follow DIV_SIGNED_EN.
module tb_divider_seq;
`ifdef DIV_SIGNED_EN
    localparam bit SG = 1'b1;
`else
    localparam bit SG = 1'b0;
`endif
    logic clk = 0, rst = 1, start = 0, s = 0;
    logic [31:0] dividend = '0, divisor = '0;
    logic busy, done, dz, ov;
    logic [31:0] quotient, remainder;
    int errs = 0, checks = 0;

    divider_seq dut (
        .clk(clk), .rst(rst), .start(start), .s(s), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dz(dz), .ov(ov)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic op(input string tag, input logic sv, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eq, input logic [31:0] er, input logic edz, input logic eov,
                      input int elat, input bit now, input int intr);
        int lat, bc;
        if (!now) @(negedge clk);
        start = 1; s = sv; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 0; lat = 0; bc = 0;
        while (!done && lat < 100) begin
            if (busy) bc++;
            if (intr != 0 && lat == intr) begin
                start = 1; s = 0; dividend = 55; divisor = 5;
            end
            @(posedge clk); #1;
            start = 0;
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(elat));
        check({tag, ".busy_cycles"}, 32'(bc), 32'(elat));
        check({tag, ".q"}, quotient, eq);
        check({tag, ".r"}, remainder, er);
        check({tag, ".dz"}, {31'b0, dz}, {31'b0, edz});
        check({tag, ".ov"}, {31'b0, ov}, {31'b0, eov});
        check({tag, ".busy_at_done"}, {31'b0, busy}, 32'h0);
    endtask

    initial begin
        int dcount;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", {31'b0, busy}, 0);
        check("rst.done", {31'b0, done}, 0);
        check("rst.q", quotient, 0);
        check("rst.r", remainder, 0);
        check("rst.dz", {31'b0, dz}, 0);
        check("rst.ov", {31'b0, ov}, 0);
        @(negedge clk) rst = 0;

        op("u100_7", 0, 100, 7, 14, 2, 0, 0, 33, 0, 0);
        op("sm100_7", 1, 32'hFFFFFF9C, 7, SG ? 32'hFFFFFFF2 : 32'h24924916,
           SG ? 32'hFFFFFFFE : 32'h2, 0, 0, 33, 0, 0);
        op("s100_m7", 1, 100, 32'hFFFFFFF9, SG ? 32'hFFFFFFF2 : 32'h0,
           SG ? 32'h2 : 32'h64, 0, 0, 33, 0, 0);
        op("u5_0", 0, 5, 0, 32'hFFFFFFFF, 5, 1, 0, 1, 0, 0);
        op("s5_0", 1, 5, 0, 32'hFFFFFFFF, 5, 1, 0, 1, 0, 0);
        op("sm7_0", 1, 32'hFFFFFFF9, 0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1, 0, 1, 0, 0);
        op("s_ovf", 1, 32'h80000000, 32'hFFFFFFFF, SG ? 32'h80000000 : 32'h0,
           SG ? 32'h0 : 32'h80000000, 0, SG, SG ? 1 : 33, 0, 0);
        op("u_ovf_ops", 0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0, 0, 33, 0, 0);
        op("s0_5", 1, 0, 5, 0, 0, 0, 0, 33, 0, 0);
        op("smin_1", 1, 32'h80000000, 1, 32'h80000000, 0, 0, 0, 33, 0, 0);
        op("ignore_start", 0, 1000, 10, 100, 0, 0, 0, 33, 0, 10);
        op("start_in_done", 0, 1000, 3, 333, 1, 0, 0, 33, 1, 0);

        @(negedge clk);
        start = 1; s = 0; dividend = 1000; divisor = 7;
        @(posedge clk); #1;
        start = 0;
        repeat (15) @(posedge clk);
        #1 rst = 1;
        #1;
        check("midrst.busy", {31'b0, busy}, 0);
        check("midrst.done", {31'b0, done}, 0);
        check("midrst.q", quotient, 0);
        check("midrst.r", remainder, 0);
        check("midrst.dz", {31'b0, dz}, 0);
        check("midrst.ov", {31'b0, ov}, 0);
        @(negedge clk) rst = 0;
        dcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("midrst.no_done", 32'(dcount), 0);
        op("u_max_1", 0, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 0, 0, 33, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/divider_seq.md
# divider_seq

Iterative 32-bit radix-2 restoring divider for the datapath, the inverse companion of the CLA adder/subtractor.
- Signed or unsigned operation, selected per operation by `s`, the same convention as the adder.
- Performs one trial subtraction per cycle and returns quotient, remainder and exception flags through a start/done handshake.
- Sits beside the ALU and is launched by the execute stage for DIV/DIVU.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width.
- `CNT_W`, 6, iteration counter width (≥ log2(WIDTH)+1).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  launch request; accepted only when `busy`=0.
- `s`  in  1  0 = unsigned, 1 = signed; sampled with `start`.
- `dividend`  in  WIDTH  numerator; sampled with `start`.
- `divisor`  in  WIDTH  denominator; sampled with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; results valid.
- `quotient`  out  WIDTH  result quotient; held until the next accepted `start`.
- `remainder`  out  WIDTH  result remainder; held until the next accepted `start`.
- `dz`  out  1  divide-by-zero flag; held with the results.
- `ov`  out  1  signed overflow flag (−2^31 / −1); held with the results.

## Operation
States: IDLE, RUN, FIX.

IDLE:
- `start`=1 → latch `s`, the sign of each operand, and the operand magnitudes (two's-complement abs when `s`=1, raw otherwise).
- Clear `dz`/`ov`; set `busy`.
- If `divisor`==0 or (`s`=1, `dividend`=0x80000000, `divisor`=0xFFFFFFFF), go to FIX with an exception marker. Otherwise go to RUN with counter=0.

RUN, one iteration per cycle:
- Shift {rem, quo} left 1.
- Trial = rem − divisor_mag (33-bit).
- If the trial is non-negative: rem = trial, quo[0] = 1. Otherwise quo[0] = 0.
- After WIDTH iterations → FIX.

FIX: apply the exception result or sign correction, drive the outputs, pulse `done`, clear `busy`, → IDLE.
- Normal signed: quotient negated if the operand signs differ; remainder takes the dividend's sign (truncating division).
- Normal unsigned: raw results.
- Divide by zero: quotient=0xFFFFFFFF, remainder=dividend, `dz`=1.
- Signed overflow: quotient=0x80000000, remainder=0, `ov`=1.

Boundary rules:
- `start` while `busy`=1 is ignored; no effect on the operation in flight.
- `start` in the cycle `done` is high is accepted (`busy` is already 0).
- `rst` at any time → IDLE. Outputs `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `dz`=0, `ov`=0. An operation in progress is discarded.
- Dividend 0 with a nonzero divisor takes the normal path: quotient 0, remainder 0.
- Negating 0x80000000 in abs wraps to 0x80000000; treat that magnitude as unsigned 2^31.

## Timing
- `start` sampled at edge N.
- Normal path: RUN occupies edges N+1..N+32, FIX at edge N+33. `done`=1 for exactly the cycle after edge N+33, so latency is 33 cycles start-edge to results.
- Exception path: FIX at edge N+1; `done` in the cycle after edge N+1.
- `busy`=1 from after edge N until the FIX edge; 0 in the `done` cycle.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
Macro `DIV_SIGNED_EN`.
- Defined: `s` honoured; sign handling, the abs/negate logic and `ov` detection are compiled in.
- Undefined: `s` is ignored and all operations are unsigned; `ov` is tied to 0; the abs/negate logic is removed. Unsigned results and timing are identical to the defined build.

## Test plan
- Unsigned 100/7 (`s`=0) → quotient=14, remainder=2, `dz`=`ov`=0, `done` 33 cycles after the start edge, `busy` high 33 cycles.
- Signed −100/7 (0xFFFFFF9C / 7, `s`=1) → quotient=0xFFFFFFF2, remainder=0xFFFFFFFE. Signed 100/−7 → quotient=0xFFFFFFF2, remainder=2.
- 5/0 (either `s`) → quotient=0xFFFFFFFF, remainder=5, `dz`=1, `done` one cycle after the start edge.
- Signed 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0, `ov`=1. The same operands unsigned → quotient=0, remainder=0x80000000, `ov`=0.
- Second `start` with new operands at cycle 10 of an operation → ignored; first results unchanged. A `start` in the `done` cycle → accepted; its `done` arrives 33 cycles later.
- `rst` pulsed at cycle 15 of an operation → all outputs 0 immediately; no `done`. A following 0xFFFFFFFF/1 unsigned → quotient=0xFFFFFFFF, remainder=0.
